// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types used by the writeback path: the writeback entry,
// the arbiter grant record, and the round-robin index helper.
package NanoCore_pkg;

  // One result from a writeback producer. The ready field travels with the
  // payload for other consumers; the arbiter does not look at it.
  typedef struct packed {
    logic        ready;
    logic [7:0]  uid;
    logic [4:0]  rf_dst;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam int WB_PORTS   = 2;
  localparam int NUM_WB_SRC = 3;

  // One regfile port's grant: whether it fires and which source feeds it.
  typedef struct packed {
    logic       valid;
    logic [1:0] src;
  } wb_grant_t;

  // (base + offset) mod num_src, for base < num_src and offset <= num_src.
  function automatic logic [1:0] src_wrap(input logic [1:0]  base,
                                          input int unsigned offset,
                                          input int unsigned num_src);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= num_src) sum = sum - num_src;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-producer writeback FIFO: count register plus wrap-around pointers.
// ready depends only on the registered count, so the producer handshake has
// no combinational path from any input. Flush empties the FIFO at the edge.
module wb_src_fifo
  import NanoCore_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push_valid,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      ready,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  wb_entry_t     mem [DEPTH];

  assign ready = (count < CNT_MAX);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // A full FIFO stays not-ready in a cycle it pops; flush swallows any push.
  assign push  = push_valid && ready && !flush;

  // Occupancy and pointers; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Payload storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count alone says which slots
    // hold live data, so clearing the payload would only cost flops.
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ex0/ex1/lsu results and grants up to two per
// cycle onto the two regfile write ports, round-robin from rr_ptr. Port 1 is
// withheld when its head targets the same nonzero register as port 0, so the
// regfile never sees two writes to one register in a cycle.
module wb_arbiter
  import NanoCore_pkg::*;
#(
  parameter int NUM_SRC    = NUM_WB_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic      [NUM_SRC-1:0]        i_src_valid,
  input  wb_entry_t [NUM_SRC-1:0]        i_src_entry,
  output logic      [NUM_SRC-1:0]        o_src_ready,
  output logic      [WB_PORTS-1:0]       o_rf_we,
  output logic      [WB_PORTS-1:0][4:0]  o_rf_waddr,
  output logic      [WB_PORTS-1:0][31:0] o_rf_wdata,
  output logic      [WB_PORTS-1:0]       o_retire_valid,
  output logic      [WB_PORTS-1:0][7:0]  o_retire_uid,
  output logic      [31:0]               o_wb_cnt
);

  wb_entry_t [NUM_SRC-1:0]      head;
  logic      [NUM_SRC-1:0]      empty;
  logic      [NUM_SRC-1:0]      pop;
  logic      [NUM_SRC-1:0][1:0] scan_src;
  wb_grant_t [WB_PORTS-1:0]     grant;
  logic                         second_seen;
  logic      [1:0]              rr_ptr;
  logic      [1:0]              grant_cnt;
  logic                         unused_ready;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .flush      (i_flush),
      .push_valid (i_src_valid[s]),
      .push_entry (i_src_entry[s]),
      .pop        (pop[s]),
      .ready      (o_src_ready[s]),
      .empty      (empty[s]),
      .head       (head[s])
    );
  end

  // The ready field of buffered entries has no meaning here.
  always_comb begin
    unused_ready = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) unused_ready ^= head[s].ready;
  end

  // Scan order for this cycle: rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) scan_src[k] = src_wrap(rr_ptr, k, NUM_SRC);
  end

  // First non-empty head takes port 0, the next one takes port 1 unless both
  // write the same nonzero register; nothing is granted during a flush.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    grant       = '0;
    second_seen = 1'b0;
    if (!i_flush) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!empty[scan_src[k]]) begin
          if (!grant[0].valid) begin
            grant[0].valid = 1'b1;
            grant[0].src   = scan_src[k];
          end else if (!second_seen) begin
            second_seen = 1'b1;
            if (!((head[scan_src[k]].rf_dst == head[grant[0].src].rf_dst) &&
                  (head[scan_src[k]].rf_dst != 5'd0))) begin
              grant[1].valid = 1'b1;
              grant[1].src   = scan_src[k];
            end
          end
        end
      end
    end
  end

  // Granted heads pop at the edge.
  always_comb begin
    pop = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (grant[p].valid) pop[grant[p].src] = 1'b1;
    end
  end

  assign grant_cnt = 2'(grant[0].valid) + 2'(grant[1].valid);

  // Round-robin pointer moves past the last granted source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            rr_ptr <= '0;
    else if (i_flush)        rr_ptr <= '0;
    else if (grant[1].valid) rr_ptr <= src_wrap(grant[1].src, 1, NUM_SRC);
    else if (grant[0].valid) rr_ptr <= src_wrap(grant[0].src, 1, NUM_SRC);
  end

  // Registered regfile writes and retire stream; idle ports keep their data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_we        <= '0;
      o_rf_waddr     <= '0;
      o_rf_wdata     <= '0;
      o_retire_valid <= '0;
      o_retire_uid   <= '0;
      o_wb_cnt       <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        o_retire_valid[p] <= grant[p].valid;
        o_rf_we[p]        <= grant[p].valid && (head[grant[p].src].rf_dst != 5'd0);
        if (grant[p].valid) begin
          o_rf_waddr[p]   <= head[grant[p].src].rf_dst;
          o_rf_wdata[p]   <= head[grant[p].src].wdata;
          o_retire_uid[p] <= head[grant[p].src].uid;
        end
      end
      o_wb_cnt <= o_wb_cnt + 32'(grant_cnt);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter. A driver steps a queue-based reference model at each
// falling edge and pushes the expected post-edge outputs into a scoreboard
// queue; a monitor pops and compares one record after every rising edge.
module tb_wb_arbiter;
  import NanoCore_pkg::*;

  localparam int NSRC  = 3;
  localparam int DEPTH = 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_flush;
  logic      [NSRC-1:0]  i_src_valid;
  wb_entry_t [NSRC-1:0]  i_src_entry;
  logic      [NSRC-1:0]  o_src_ready;
  logic      [1:0]       o_rf_we;
  logic      [1:0][4:0]  o_rf_waddr;
  logic      [1:0][31:0] o_rf_wdata;
  logic      [1:0]       o_retire_valid;
  logic      [1:0][7:0]  o_retire_uid;
  logic      [31:0]      o_wb_cnt;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.NUM_SRC(NSRC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_src_valid    (i_src_valid),
    .i_src_entry    (i_src_entry),
    .o_src_ready    (o_src_ready),
    .o_rf_we        (o_rf_we),
    .o_rf_waddr     (o_rf_waddr),
    .o_rf_wdata     (o_rf_wdata),
    .o_retire_valid (o_retire_valid),
    .o_retire_uid   (o_retire_uid),
    .o_wb_cnt       (o_wb_cnt)
  );

  typedef struct {
    logic [1:0]  retire_valid;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [15:0] uid;
    logic [31:0] wb_cnt;
  } exp_t;

  // Reference model state: buffered entries per source, producer backlog,
  // round-robin start, retire count and last values held by each port.
  wb_entry_t   mq   [NSRC][$];
  wb_entry_t   pend [NSRC][$];
  exp_t        exp_q[$];
  int          rr;
  logic [31:0] m_cnt;
  logic [4:0]  last_addr [2];
  logic [31:0] last_data [2];
  logic [7:0]  last_uid  [2];
  logic [7:0]  uid_ctr;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic wb_entry_t mk(input logic [7:0] uid, input logic [4:0] dst, input logic [31:0] d);
    wb_entry_t e;
    e.ready  = 1'($urandom_range(0, 1));
    e.uid    = uid;
    e.rf_dst = dst;
    e.wdata  = d;
    return e;
  endfunction

  task automatic send(input int s, input logic [7:0] uid, input logic [4:0] dst, input logic [31:0] d);
    pend[s].push_back(mk(uid, dst, d));
  endtask

  task automatic send_auto(input int s, input logic [4:0] dst);
    send(s, uid_ctr, dst, $urandom);
    uid_ctr++;
  endtask

  function automatic bit busy();
    for (int s = 0; s < NSRC; s++) if (mq[s].size() > 0 || pend[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NSRC; s++) begin
      mq[s].delete();
      pend[s].delete();
    end
    exp_q.delete();
    rr    = 0;
    m_cnt = '0;
    for (int p = 0; p < 2; p++) begin
      last_addr[p] = '0;
      last_data[p] = '0;
      last_uid[p]  = '0;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rf_we",        64'(o_rf_we),        64'd0);
    check("rst_retire_valid", 64'(o_retire_valid), 64'd0);
    check("rst_rf_waddr",     64'(o_rf_waddr),     64'd0);
    check("rst_rf_wdata",     64'(o_rf_wdata),     64'd0);
    check("rst_retire_uid",   64'(o_retire_uid),   64'd0);
    check("rst_wb_cnt",       64'(o_wb_cnt),       64'd0);
    check("rst_src_ready",    64'(o_src_ready),    64'h7);
  endtask

  // One clock of stimulus plus the model's view of what the next edge does.
  task automatic step(input bit flush);
    logic [NSRC-1:0] exp_ready;
    logic [NSRC-1:0] acc;
    int              sizes [NSRC];
    int              cand[$];
    int              g [2];
    exp_t            e;
    wb_entry_t       ent;
    for (int s = 0; s < NSRC; s++) begin
      sizes[s]     = mq[s].size();
      exp_ready[s] = (sizes[s] < DEPTH);
    end
    check("src_ready", 64'(o_src_ready), 64'(exp_ready));
    i_flush = flush;
    for (int s = 0; s < NSRC; s++) begin
      acc[s] = 1'b0;
      if (pend[s].size() > 0) begin
        i_src_valid[s] = 1'b1;
        i_src_entry[s] = pend[s][0];
        acc[s]         = exp_ready[s];
      end else begin
        i_src_valid[s] = 1'b0;
        i_src_entry[s] = mk(8'($urandom), 5'($urandom), $urandom);
      end
    end
    g[0] = -1;
    g[1] = -1;
    if (!flush) begin
      for (int k = 0; k < NSRC; k++) if (sizes[(rr + k) % NSRC] > 0) cand.push_back((rr + k) % NSRC);
      if (cand.size() > 0) g[0] = cand[0];
      if (cand.size() > 1 &&
          !(mq[cand[0]][0].rf_dst == mq[cand[1]][0].rf_dst && mq[cand[1]][0].rf_dst != 5'd0))
        g[1] = cand[1];
    end
    e.retire_valid = '0;
    e.we           = '0;
    for (int p = 0; p < 2; p++) begin
      if (g[p] >= 0) begin
        ent               = mq[g[p]].pop_front();
        e.retire_valid[p] = 1'b1;
        e.we[p]           = (ent.rf_dst != 5'd0);
        last_addr[p]      = ent.rf_dst;
        last_data[p]      = ent.wdata;
        last_uid[p]       = ent.uid;
        m_cnt++;
        rr = (g[p] + 1) % NSRC;
      end
    end
    e.waddr  = {last_addr[1], last_addr[0]};
    e.wdata  = {last_data[1], last_data[0]};
    e.uid    = {last_uid[1], last_uid[0]};
    e.wb_cnt = m_cnt;
    if (flush) begin
      for (int s = 0; s < NSRC; s++) mq[s].delete();
      rr = 0;
    end
    for (int s = 0; s < NSRC; s++) begin
      if (acc[s]) begin
        ent = pend[s].pop_front();
        if (!flush) mq[s].push_back(ent);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit flush);
    @(negedge i_clk);
    step(flush);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_src_valid = '0;
    #1;
    check_reset_outputs();
    model_clear();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Monitor: compare the registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("retire_valid", 64'(o_retire_valid), 64'(e.retire_valid));
        check("rf_we",        64'(o_rf_we),        64'(e.we));
        check("rf_waddr",     64'(o_rf_waddr),     64'(e.waddr));
        check("rf_wdata",     64'(o_rf_wdata),     e.wdata);
        check("retire_uid",   64'(o_retire_uid),   64'(e.uid));
        check("wb_cnt",       64'(o_wb_cnt),       64'(e.wb_cnt));
      end else if (o_retire_valid !== 2'b00) begin
        check("unexpected_retire", 64'(o_retire_valid), 64'd0);
      end
      if (o_rf_we == 2'b11)
        check("dual_port_same_dst", 64'(o_rf_waddr[0] == o_rf_waddr[1]), 64'd0);
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_src_valid = '0;
    i_src_entry = '0;
    uid_ctr     = 8'd20;
    model_clear();
    do_reset();

    // Single ex0 entry.
    send(0, 8'd5, 5'd3, 32'hDEADBEEF);
    idle(4);
    // All three sources in one cycle with distinct destinations.
    send(0, 8'd10, 5'd1, 32'h1111_0001);
    send(1, 8'd11, 5'd2, 32'h2222_0002);
    send(2, 8'd12, 5'd4, 32'h4444_0004);
    idle(5);
    // Same-destination hazard between ex0 and ex1.
    send(0, 8'd13, 5'd7, 32'h7777_0000);
    send(1, 8'd14, 5'd7, 32'h7777_0001);
    idle(5);
    // x0 destination from lsu: retire without write.
    send(2, 8'd9, 5'd0, 32'h0BAD_F00D);
    idle(4);
    // Backpressure: a continuous hazard between ex0 and ex1 on register 5.
    for (int i = 0; i < 4; i++) begin
      send(0, 8'(30 + i), 5'd5, $urandom);
      send(1, 8'(40 + i), 5'd5, $urandom);
    end
    idle(14);
    // Flush with every FIFO loaded.
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < NSRC; s++) send_auto(s, 5'(1 + s + 3 * i));
    idle(2);
    cycle(1'b1);
    idle(4);

    // Randomized traffic with occasional flush and one mid-stream reset.
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NSRC; s++)
        if (pend[s].size() < 3 && $urandom_range(0, 99) < 45) send_auto(s, 5'($urandom_range(0, 7)));
      if (c == 700) do_reset();
      else          cycle($urandom_range(0, 59) == 0);
    end

    for (int i = 0; i < 60 && busy(); i++) cycle(1'b0);
    if (busy()) check("drain_timeout", 64'd1, 64'd0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the two register-file write ports of the two-issue core among NUM_SRC writeback producers: ex0, ex1 and lsu, in that index order.
- Buffers each producer's wb_entry_t in a small per-source FIFO and grants up to two entries per cycle, round-robin.
- Drives registered regfile writes, plus a retire stream (uid) that the scoreboard uses to release destinations.
- Sits between the execute/LSU stages and the regfile/scoreboard.

Parameters:
- NUM_SRC, 3, number of writeback producers (index 0=ex0, 1=ex1, 2=lsu).
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  pipeline flush; discard all buffered entries.
- i_src_valid  in  NUM_SRC  producer s presents an entry.
- i_src_entry  in  NUM_SRC x wb_entry_t  entry payload; .ready is ignored.
- o_src_ready  out  NUM_SRC  FIFO s can accept.
- o_rf_we  out  2  write enable per regfile port.
- o_rf_waddr  out  2x5  destination register per port.
- o_rf_wdata  out  2x32  write data per port.
- o_retire_valid  out  2  port p retires an entry (also set when rf_dst==0).
- o_retire_uid  out  2x8  uid retired on port p.
- o_wb_cnt  out  32  total retired entries, wraps modulo 2^32.

Behaviour:
- Reset (async, i_rst_n=0): all FIFOs empty, rr_ptr=0, and o_rf_we, o_rf_waddr, o_rf_wdata, o_retire_valid, o_retire_uid, o_wb_cnt all 0. o_src_ready is all-1, since it is derived from count=0.
- Reset asserted mid-operation drops all buffered entries.
- Handshake:
  - Enqueue when i_src_valid[s] && o_src_ready[s] at a rising edge.
  - o_src_ready[s] = (count[s] < FIFO_DEPTH), decoded from registered state only; there is no combinational path from any input.
  - A full FIFO does not accept in the same cycle it pops. The producer holds valid and payload until accepted.
- FIFO: per source, a count register plus wrap-around read/write pointers. Push and pop in the same cycle leave count unchanged.
- Arbitration (combinational on FIFO heads, every cycle while i_flush=0):
  - Scan sources in the order rr_ptr, rr_ptr+1, … mod NUM_SRC. The first non-empty head gets port 0; the next non-empty head gets port 1.
  - Hazard: if both selected heads have equal nonzero rf_dst, port 1 is not granted that cycle and the second entry waits.
  - The scan takes at most one entry per source per cycle.
  - Granted heads pop at the edge.
  - rr_ptr <= (index of last granted source + 1) mod NUM_SRC. rr_ptr is unchanged if nothing is granted.
- Outputs (registered, 1 cycle after grant):
  - o_retire_valid[p] = granted.
  - o_rf_we[p] = granted && rf_dst != 0.
  - Address, data and uid come from the granted entry.
  - Ungranted ports drive we=0 and retire_valid=0; data fields hold their last values.
- Latency: accept at edge t → head visible after t → write at edge t+1 → outputs valid in cycle t+1..t+2. Minimum is 2 cycles, input handshake to o_rf_we.
- o_wb_cnt increments by popcount(grants) each cycle and wraps from 0xFFFFFFFF.
- Flush:
  - i_flush=1 in cycle t → no grants in t, and all counts and pointers are cleared at edge t.
  - Enqueues in cycle t are discarded.
  - rr_ptr resets to 0.
  - Outputs registered at edge t show we=0 and retire_valid=0.
  - o_wb_cnt is not cleared.
- Port 0 and port 1 never carry the same nonzero rf_dst in one cycle. The regfile needs no write-conflict resolution.

Decomposition:
- NanoCore_pkg already holds wb_entry_t.
- Add to it: localparam WB_PORTS=2 and localparam NUM_WB_SRC=3, and typedef wb_grant_t (logic valid, logic [1:0] src).
- One natural sub-module: wb_src_fifo (wb_entry_t FIFO with count, ready, flush), instantiated NUM_SRC times.
- Arbitration and the output registers stay in wb_arbiter.

Test Plan:
- Single source: ex0 sends {uid=5, rf_dst=3, wdata=0xDEADBEEF} → two cycles later o_rf_we[0]=1, waddr=3, wdata=0xDEADBEEF, retire_uid=5; o_wb_cnt=1.
- Three sources valid in one cycle (rf_dst 1, 2, 4), rr_ptr=0 → first write cycle: port0=ex0, port1=ex1; next cycle: port0=lsu; rr_ptr sequence 0→2→0.
- Same-destination hazard: ex0 and ex1 both rf_dst=7 → port0 ex0 in cycle n, ex1 in cycle n+1; never both ports waddr=7.
- rf_dst=0 from lsu uid=9 → o_retire_valid=1, uid=9, o_rf_we=0.
- Backpressure: hold ex1 valid for 4 cycles while grants are masked by a continuous hazard with ex0 → o_src_ready[1]=0 after 2 accepts; all uids retire in order with none lost.
- Flush with 2 entries buffered per source → no retire in the following cycles; o_src_ready all 1; o_wb_cnt unchanged. Also assert i_rst_n=0 mid-stream → all outputs 0 immediately.
